uop_queue_ctrl: RTL

Controller for the micro-op queue between the decoder and issue logic. Each cycle it accepts a group of up to IN_UOP decoded uops and stores them in a QU_UOP-entry circular buffer. It issues OUT_UOP (=1) uop per cycle over a valid/ready handshake. It stamps every stored uop with the current colour (epoch), and on flush it empties the queue and advances the colour.

---
 rtl/uop_queue_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uop_queue_ctrl.sv
// Micro-op queue between decode and issue: circular buffer with colour stamping and flush.
// Optional statistics outputs are compiled in when UOP_QUEUE_STATS_EN is defined.

package UOP;
  localparam int IN_UOP = 5;
  localparam int QU_UOP = 16;

  typedef logic [3:0] uop_color_t;

  typedef struct packed {
    logic [7:0] name;
    logic [5:0] dest;
    logic [5:0] src;
    uop_color_t color;
  } uop_ins_t;
endpackage

module uop_queue_ctrl #(
  parameter int IN_UOP  = UOP::IN_UOP,
  parameter int QU_UOP  = UOP::QU_UOP,
  parameter int OUT_UOP = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [IN_UOP-1:0][$bits(UOP::uop_ins_t)-1:0] in_uops,
  input  logic [2:0]                                 in_count,
  output logic                                       in_ready,
  output logic [$bits(UOP::uop_ins_t)-1:0]           out_uop,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  input  logic                                       flush,
  output logic [3:0]                                 cur_color,
  output logic [$clog2(QU_UOP):0]                    occupancy
`ifdef UOP_QUEUE_STATS_EN
  ,
  output logic [15:0]                                stat_stall_cnt,
  output logic [15:0]                                stat_issue_cnt
`endif
);

  localparam int PW = $clog2(QU_UOP);
  localparam int OW = PW + 1;
  localparam int UW = $bits(UOP::uop_ins_t);
  localparam int CW = $bits(UOP::uop_color_t);

  if (OUT_UOP != 1) begin : g_bad_out_uop
    $error("uop_queue_ctrl supports OUT_UOP == 1 only");
  end
  if ((1 << PW) != QU_UOP || QU_UOP < IN_UOP) begin : g_bad_depth
    $error("QU_UOP must be a power of two no smaller than IN_UOP");
  end

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [OW-1:0]  occ;
  logic [CW-1:0]  color;
  logic [UW-1:0]  mem [QU_UOP];

  logic                       cnt_legal;
  logic                       enq;
  logic                       deq;
  logic [OW-1:0]              add;
  logic [OW-1:0]              occ_next;
  logic [IN_UOP-1:0][UW-1:0]  wr_data;

  // Handshakes: the producer group transfers on a cycle where in_ready is high and
  // in_count is legal; the head uop transfers on a cycle where out_valid && out_ready.
  // A flush in the same cycle cancels both transfers.
  assign cnt_legal = (in_count != 3'd0) && (int'(in_count) <= IN_UOP);
  assign in_ready  = (int'(occ) + IN_UOP) <= QU_UOP;
  assign out_valid = (occ != '0);
  assign enq       = in_ready && cnt_legal && !flush;
  assign deq       = out_valid && out_ready && !flush;
  assign add       = enq ? OW'(in_count) : '0;
  assign occ_next  = occ + add - OW'(deq);

  assign out_uop   = out_valid ? mem[head] : '0;
  assign cur_color = color;
  assign occupancy = occ;

  // Colour occupies the low bits of the uop word and is replaced on write.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < IN_UOP; i++) begin
      wr_data[i] = {in_uops[i][UW-1:CW], color};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
      color <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
      color <= color + 1'b1;
    end else begin
      if (enq) tail <= tail + PW'(in_count);
      if (deq) head <= head + 1'b1;
      occ <= occ_next;
    end
  end

  // Storage is not reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_UOP; i++) begin
      if (enq && (i < int'(in_count))) begin
        mem[tail + PW'(i)] <= wr_data[i];
      end
    end
  end

`ifdef UOP_QUEUE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else if (!flush) begin
      if (cnt_legal && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
      if (deq && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  assign stat_stall_cnt = stall_cnt;
  assign stat_issue_cnt = issue_cnt;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (int'(occ) + int'(add) - int'(deq)) <= QU_UOP)
    else $error("uop queue overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(deq && occ == '0))
    else $error("uop queue underflow");

endmodule
